interpolator_mc: RTL
====================

Name: interpolator_mc

Overview:
Multi-channel, parametrised successor to the single-channel DDS interpolator. It takes NCH oscillator state words per sample strobe from the oscillator bank and upsamples each channel by L = 2^LOG2_L using linear interpolation. It truncates each channel to DAC width and drives offset-binary DAC codes. Sits between the oscillator bank and the DAC drivers, clocked by the 24 MHz function-generator clock.

Parameters:
NCH, 2, number of channels
DIN_W, 32, oscillator state word width per channel
DOUT_W, 12, DAC code width per channel
LOG2_L, 3, log2 of interpolation factor L (L = 8 by default)

Ports:
Fg_CLK  input  1  system clock, rising-edge
RESET  input  1  asynchronous, active-high reset
Enable  input  1  one-cycle sample strobe; new samples on din are valid this cycle
din  input  NCH*DIN_W  packed signed samples; channel c = din[c*DIN_W +: DIN_W]
Mode  input  4  Mode[1:0] = interpolation mode; Mode[3:2] reserved, ignored
osc_out  output  NCH*DOUT_W  packed offset-binary DAC codes
out_valid  output  1  high once the first sample has propagated to osc_out
phase  output  LOG2_L+1  current interpolation index k

Behaviour:
- Reset: all registers cleared. osc_out = {NCH{1'b1, (DOUT_W-1)'b0}} (midscale 0x800). out_valid = 0, phase = 0, primed = 0, mode register = 0.
- Truncation: s_c = din_c[DIN_W-1 -: DOUT_W], signed.
- On Enable:
  - If primed = 0: prev_c = cur_c = s_c and primed is set, so there is no ramp from zero.
  - Otherwise: prev_c = cur_c and cur_c = s_c.
  - k = 0 and mode_r = Mode[1:0]. Mode is latched only on Enable.
- Phase counter k:
  - Increments by 1 every Fg_CLK cycle after Enable.
  - Saturates at L, which gives output = cur.
  - Enable on any cycle, including before k reaches L, restarts the ramp from the current prev/cur update. The ramp does not jump to the new sample.
- Arithmetic per channel:
  - d = cur - prev, DOUT_W+1 bits signed.
  - p = d*k, DOUT_W+LOG2_L+2 bits signed.
  - y = prev + (p >>> LOG2_L), arithmetic shift, floor.
  - y always lies within [min(prev,cur), max(prev,cur)] and fits DOUT_W.
- Modes (mode_r):
  - 0 = linear: y as above.
  - 1 = hold: y = cur.
  - 2 = mute: y = 0.
  - 3 = inverted linear: y' = -y; y = -2^(DOUT_W-1) saturates to 2^(DOUT_W-1)-1.
- Pipeline: 2 stages. Stage 1 registers d*k and prev; stage 2 registers the offset-binary code (y with MSB inverted).
- Latency: the value for phase k appears on osc_out two Fg_CLK edges after k is registered.
- out_valid goes high 2 cycles after the first Enable and stays high until reset.
- phase is the stage-2-aligned k.
- Reset mid-operation: immediate return to reset values. The first Enable after release re-primes.

Optional Feature:
INTERP_MIX_EN:
- When defined, adds output mix_out, DOUT_W bits, offset binary, 2-cycle latency aligned with osc_out.
- mix_out is the sum of all NCH signed y values, saturated to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
- When undefined, the port and adder tree are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then first Enable with ch0 din = 32'h1000_0000 -> ch0 code 0x900 (prev = cur = 256, no ramp); out_valid rises 2 cycles after Enable.
- Mode 0, next Enable with ch0 din = 32'h2000_0000 -> ch0 codes 0x900, 0x920, 0x940 … 0x9E0, 0xA00, then held at 0xA00; phase runs 0..8.
- Mode 0, ch1 descending 512 -> -512 (din 32'h2000_0000 then 32'hE000_0000) -> codes step by -128 with floor rounding, ending at 0x600; no overflow.
- Mode 3 with sample -2048 (din 32'h8000_0000) held -> code 0xFFF (saturated +2047). Mode 2 -> all channels 0x800. A Mode change between strobes takes effect only at the next Enable.
- Enable at k = 3 mid-ramp -> k restarts at 0, prev = old cur, no glitch beyond the new ramp; RESET asserted mid-ramp -> osc_out = 0x800 and out_valid = 0 immediately.
- INTERP_MIX_EN, NCH = 2, both channels at +1500 -> mix_out = 0xFFF (saturated); +1000 and -400 -> mix_out = 0xA58.

Source files
------------

// File: rtl/interpolator_mc.sv
// interpolator_mc: NCH-channel linear-interpolating upsampler (L = 2^LOG2_L).
// Each channel is truncated to DOUT_W bits, ramped from the previous sample to
// the current one over L clocks, and driven out as an offset-binary DAC code.
// Optional summed output mix_out is enabled by defining INTERP_MIX_EN.
module interpolator_mc #(
    parameter int NCH    = 2,
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 12,
    parameter int LOG2_L = 3
) (
    input  logic                    Fg_CLK,
    input  logic                    RESET,
    input  logic                    Enable,
    input  logic [NCH*DIN_W-1:0]    din,
    input  logic [3:0]              Mode,
    output logic [NCH*DOUT_W-1:0]   osc_out,
    output logic                    out_valid,
    output logic [LOG2_L:0]         phase
`ifdef INTERP_MIX_EN
    ,
    output logic [DOUT_W-1:0]       mix_out
`endif
);
    localparam int                       PW    = DOUT_W + LOG2_L + 2;
    localparam logic [LOG2_L:0]          L_MAX = {1'b1, {LOG2_L{1'b0}}};
    localparam logic [DOUT_W-1:0]        MID   = {1'b1, {(DOUT_W-1){1'b0}}};
    localparam logic signed [DOUT_W-1:0] Y_MIN = MID;
    localparam logic signed [DOUT_W-1:0] Y_MAX = ~MID;

    logic            primed_q;
    logic [1:0]      mode_q, mode1_q;
    logic [LOG2_L:0] k_q, k_d, k1_q, phase_q;
    logic            v1_q, valid_q;
    logic            mode_unused;

    assign mode_unused = ^Mode[3:2];

    // Phase restarts on a strobe, otherwise counts up and parks at L once primed
    always_comb begin
        k_d = k_q;
        if (Enable)
            k_d = '0;
        else if (primed_q && k_q != L_MAX)
            k_d = k_q + 1'b1;
    end

    // Strobe-side control: phase counter, latched mode, primed flag
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            primed_q <= 1'b0;
            mode_q   <= '0;
            k_q      <= '0;
        end else begin
            k_q <= k_d;
            if (Enable) begin
                primed_q <= 1'b1;
                mode_q   <= Mode[1:0];
            end
        end
    end

    // Control travelling alongside the two datapath stages
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            v1_q    <= 1'b0;
            mode1_q <= '0;
            k1_q    <= '0;
            valid_q <= 1'b0;
            phase_q <= '0;
        end else begin
            v1_q    <= primed_q;
            mode1_q <= mode_q;
            k1_q    <= k_q;
            valid_q <= v1_q;
            phase_q <= k1_q;
        end
    end

    assign out_valid = valid_q;
    assign phase     = phase_q;

`ifdef INTERP_MIX_EN
    logic [NCH-1:0][DOUT_W-1:0] y_all;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [DOUT_W-1:0] s, prev_q, cur_q, prev1_q, cur1_q, y_lin, y_sel;
        logic signed [DOUT_W:0]   d;
        logic signed [PW-1:0]     p, p1_q, y_w;
        logic [DOUT_W-1:0]        code_q;
        logic                     ch_unused;

        assign s         = din[c*DIN_W + DIN_W-1 -: DOUT_W];
        assign ch_unused = ^{y_w[PW-1:DOUT_W], din[c*DIN_W +: DIN_W-DOUT_W]};

        // Sample history; the first strobe loads both so the ramp never starts at zero
        always_ff @(posedge Fg_CLK or posedge RESET) begin
            if (RESET) begin
                prev_q <= '0;
                cur_q  <= '0;
            end else if (Enable) begin
                prev_q <= primed_q ? cur_q : s;
                cur_q  <= s;
            end
        end

        assign d = {cur_q[DOUT_W-1], cur_q} - {prev_q[DOUT_W-1], prev_q};
        assign p = PW'(d) * PW'($signed({1'b0, k_q}));

        // Stage 1: slope times phase, plus endpoints
        always_ff @(posedge Fg_CLK or posedge RESET) begin
            if (RESET) begin
                p1_q    <= '0;
                prev1_q <= '0;
                cur1_q  <= '0;
            end else begin
                p1_q    <= p;
                prev1_q <= prev_q;
                cur1_q  <= cur_q;
            end
        end

        // Floor division by L via arithmetic shift keeps y between the endpoints
        assign y_w   = PW'(prev1_q) + (p1_q >>> LOG2_L);
        assign y_lin = y_w[DOUT_W-1:0];

        // Output mode select; negating the most negative code saturates
        always_comb begin
            y_sel = y_lin;
            case (mode1_q)
                2'd1:    y_sel = cur1_q;
                2'd2:    y_sel = '0;
                2'd3:    y_sel = (y_lin == Y_MIN) ? Y_MAX : -y_lin;
                default: y_sel = y_lin;
            endcase
        end

        // Stage 2: offset-binary code
        always_ff @(posedge Fg_CLK or posedge RESET) begin
            if (RESET)
                code_q <= MID;
            else
                code_q <= {~y_sel[DOUT_W-1], y_sel[DOUT_W-2:0]};
        end

        assign osc_out[c*DOUT_W +: DOUT_W] = code_q;
`ifdef INTERP_MIX_EN
        assign y_all[c] = y_sel;
`endif
    end

`ifdef INTERP_MIX_EN
    localparam int SW = DOUT_W + $clog2(NCH) + 1;
    logic signed [SW-1:0]     mix_sum;
    logic signed [DOUT_W-1:0] mix_sat;
    logic [DOUT_W-1:0]        mix_q;

    // Sum of all channel values, clamped to the DAC range
    always_comb begin
        mix_sum = '0;
        for (int c = 0; c < NCH; c++)
            mix_sum = mix_sum + SW'($signed(y_all[c]));
        if (mix_sum > SW'(Y_MAX))
            mix_sat = Y_MAX;
        else if (mix_sum < SW'(Y_MIN))
            mix_sat = Y_MIN;
        else
            mix_sat = mix_sum[DOUT_W-1:0];
    end

    // Mix register, aligned with the stage-2 channel codes
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET)
            mix_q <= MID;
        else
            mix_q <= {~mix_sat[DOUT_W-1], mix_sat[DOUT_W-2:0]};
    end

    assign mix_out = mix_q;
`endif
endmodule
